// File: rtl/nios2_c_clk_pkg.sv
// Shared types and defaults for the Nios II PLL reset sequencer.
package nios2_c_clk_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RELEASE,
      ST_RUN
   } pll_seq_state_t;

   localparam int unsigned DEF_NUM_CH         = 4;
   localparam int unsigned DEF_SYNC_STAGES    = 2;
   localparam int unsigned DEF_PLL_RST_CYCLES = 8;
   localparam int unsigned DEF_LOCK_STABLE    = 1024;
   localparam int unsigned DEF_STAGE_DLY      = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT   = 65536;
   localparam int unsigned DEF_CNT_W          = 8;

   // Width able to hold values 0..val, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned val);
      return (val < 1) ? 1 : $clog2(val + 1);
   endfunction

endpackage

// File: rtl/nios2_c_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level, reset to 0.
module nios2_c_bit_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/nios2_c_pll_reset_seq.sv
// PLL reset / lock-qualified staggered domain reset sequencer.
// Define NIOS2_C_PLL_RETRY_EN to re-pulse the PLL reset after a lock timeout.
module nios2_c_pll_reset_seq
   import nios2_c_clk_pkg::*;
#(
   parameter int unsigned NUM_CH         = DEF_NUM_CH,
   parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
   parameter int unsigned STAGE_DLY      = DEF_STAGE_DLY,
   parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int unsigned CNT_W          = DEF_CNT_W
) (
   input  logic              refclk_i,
   input  logic              rst_n_i,
   input  logic              pll_locked_i,
   input  logic              sw_reset_req_i,
   output logic              pll_rst_o,
   output logic [NUM_CH-1:0] ch_rst_n_o,
   output logic              all_ready_o,
   output logic              timeout_err_o,
   output logic [CNT_W-1:0]  lock_loss_cnt_o
);

   localparam int unsigned RW = cnt_width(PLL_RST_CYCLES);
   localparam int unsigned TW = cnt_width(LOCK_TIMEOUT);
   localparam int unsigned SW = cnt_width(LOCK_STABLE);
   localparam int unsigned DW = cnt_width(STAGE_DLY);
   localparam int unsigned IW = cnt_width(NUM_CH);

   localparam logic [RW-1:0]    RST_LAST = RW'(PLL_RST_CYCLES - 1);
   localparam logic [TW-1:0]    TO_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0]    TO_MAX   = TW'(LOCK_TIMEOUT);
   localparam logic [SW-1:0]    STAB_MAX = SW'(LOCK_STABLE);
   localparam logic [DW-1:0]    DLY_LAST = DW'(STAGE_DLY - 1);
   localparam logic [IW-1:0]    CH_LAST  = IW'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] LOSS_MAX = '1;

   logic lock_s;

   nios2_c_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
      .clk_i   (refclk_i),
      .rst_n_i (rst_n_i),
      .d_i     (pll_locked_i),
      .q_o     (lock_s)
   );

   pll_seq_state_t    state_q, state_d;
   logic              pll_rst_q, pll_rst_d;
   logic [NUM_CH-1:0] ch_q, ch_d;
   logic              rdy_q, rdy_d;
   logic              terr_q, terr_d;
   logic [CNT_W-1:0]  loss_q, loss_d;
   logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
   logic [TW-1:0]     to_cnt_q, to_cnt_d;
   logic [SW-1:0]     stab_cnt_q, stab_cnt_d;
   logic [DW-1:0]     stg_cnt_q, stg_cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [SW-1:0]     stab_inc;
   logic              lock_loss;

   always_comb begin
      state_d    = state_q;
      pll_rst_d  = pll_rst_q;
      ch_d       = ch_q;
      rdy_d      = rdy_q;
      terr_d     = terr_q;
      loss_d     = loss_q;
      // Per-state counters fall back to zero, so every state entry starts clean.
      rst_cnt_d  = '0;
      to_cnt_d   = '0;
      stab_cnt_d = '0;
      stg_cnt_d  = '0;
      idx_d      = '0;
      stab_inc   = ((state_q == ST_STABLE) ? stab_cnt_q : '0) + SW'(1);
      lock_loss  = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lock_s;

      if (lock_loss && (loss_q != LOSS_MAX)) loss_d = loss_q + CNT_W'(1);

      if (sw_reset_req_i) begin
         state_d   = ST_PLL_RST;
         pll_rst_d = 1'b1;
         ch_d      = '0;
         rdy_d     = 1'b0;
      end else if (lock_loss) begin
         state_d = ST_WAIT_LOCK;
         ch_d    = '0;
         rdy_d   = 1'b0;
      end else begin
         case (state_q)
            ST_PLL_RST: begin
               if (rst_cnt_q == RST_LAST) begin
                  state_d   = ST_WAIT_LOCK;
                  pll_rst_d = 1'b0;
               end else begin
                  rst_cnt_d = rst_cnt_q + RW'(1);
               end
            end
            ST_WAIT_LOCK, ST_STABLE: begin
               if (lock_s) begin
                  if (stab_inc == STAB_MAX) begin
                     ch_d[0] = 1'b1;
                     if (NUM_CH == 1) begin
                        state_d = ST_RUN;
                        rdy_d   = 1'b1;
                     end else begin
                        state_d = ST_RELEASE;
                        idx_d   = IW'(1);
                     end
                  end else begin
                     state_d    = ST_STABLE;
                     stab_cnt_d = stab_inc;
                  end
               end else if (state_q == ST_STABLE) begin
                  state_d = ST_WAIT_LOCK;
               end else if (to_cnt_q == TO_MAX) begin
                  to_cnt_d = to_cnt_q;
               end else if (to_cnt_q == TO_LAST) begin
                  terr_d = 1'b1;
`ifdef NIOS2_C_PLL_RETRY_EN
                  state_d   = ST_PLL_RST;
                  pll_rst_d = 1'b1;
`else
                  to_cnt_d  = TO_MAX;
`endif
               end else begin
                  to_cnt_d = to_cnt_q + TW'(1);
               end
            end
            ST_RELEASE: begin
               if (stg_cnt_q == DLY_LAST) begin
                  ch_d = ch_q | (NUM_CH'(1) << idx_q);
                  if (idx_q == CH_LAST) begin
                     state_d = ST_RUN;
                     rdy_d   = 1'b1;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end else begin
                  stg_cnt_d = stg_cnt_q + DW'(1);
                  idx_d     = idx_q;
               end
            end
            ST_RUN: ;
            default: begin
               state_d   = ST_PLL_RST;
               pll_rst_d = 1'b1;
               ch_d      = '0;
               rdy_d     = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge refclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_PLL_RST;
         pll_rst_q  <= 1'b1;
         ch_q       <= '0;
         rdy_q      <= 1'b0;
         terr_q     <= 1'b0;
         loss_q     <= '0;
         rst_cnt_q  <= '0;
         to_cnt_q   <= '0;
         stab_cnt_q <= '0;
         stg_cnt_q  <= '0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         pll_rst_q  <= pll_rst_d;
         ch_q       <= ch_d;
         rdy_q      <= rdy_d;
         terr_q     <= terr_d;
         loss_q     <= loss_d;
         rst_cnt_q  <= rst_cnt_d;
         to_cnt_q   <= to_cnt_d;
         stab_cnt_q <= stab_cnt_d;
         stg_cnt_q  <= stg_cnt_d;
         idx_q      <= idx_d;
      end
   end

   assign pll_rst_o       = pll_rst_q;
   assign ch_rst_n_o      = ch_q;
   assign all_ready_o     = rdy_q;
   assign timeout_err_o   = terr_q;
   assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_nios2_c_pll_reset_seq.sv
// Directed bench for nios2_c_pll_reset_seq; cycle c = value sampled 1 time unit after edge c.
module tb_nios2_c_pll_reset_seq;

   logic       refclk;
   logic       rst_n;
   logic       pll_locked;
   logic       sw_reset_req;
   logic       pll_rst;
   logic [3:0] ch_rst_n;
   logic       all_ready;
   logic       timeout_err;
   logic [1:0] lock_loss_cnt;

   int cyc;
   int checks;
   int errors;

   nios2_c_pll_reset_seq #(
      .NUM_CH(4), .SYNC_STAGES(2), .PLL_RST_CYCLES(3), .LOCK_STABLE(8),
      .STAGE_DLY(4), .LOCK_TIMEOUT(32), .CNT_W(2)
   ) dut (
      .refclk_i        (refclk),
      .rst_n_i         (rst_n),
      .pll_locked_i    (pll_locked),
      .sw_reset_req_i  (sw_reset_req),
      .pll_rst_o       (pll_rst),
      .ch_rst_n_o      (ch_rst_n),
      .all_ready_o     (all_ready),
      .timeout_err_o   (timeout_err),
      .lock_loss_cnt_o (lock_loss_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic tick();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Holds reset for a few edges, checks reset values, and releases just after edge 0.
   task automatic do_reset();
      rst_n        = 1'b0;
      pll_locked   = 1'b0;
      sw_reset_req = 1'b0;
      repeat (3) @(posedge refclk);
      #1;
      chk("rst_pll_rst", pll_rst, 1);
      chk("rst_ch", ch_rst_n, 4'b0000);
      chk("rst_ready", all_ready, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_loss", lock_loss_cnt, 0);
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      int c;
      cyc = 0; checks = 0; errors = 0;

      // Power-on sequence
      do_reset();
      run_to(2);  chk("po_pll_rst_hi", pll_rst, 1);
      run_to(3);  chk("po_pll_rst_lo", pll_rst, 0);
      run_to(10); pll_locked = 1'b1;
      run_to(19); chk("po_ch_19", ch_rst_n, 4'b0000);
      run_to(20); chk("po_ch_20", ch_rst_n, 4'b0001);
      run_to(23); chk("po_ch_23", ch_rst_n, 4'b0001);
      run_to(24); chk("po_ch_24", ch_rst_n, 4'b0011);
      run_to(28); chk("po_ch_28", ch_rst_n, 4'b0111);
      run_to(31); chk("po_rdy_31", all_ready, 0);
      run_to(32); chk("po_ch_32", ch_rst_n, 4'b1111);
                  chk("po_rdy_32", all_ready, 1);

      // One-cycle lock glitch while counting stability
      do_reset();
      run_to(10); pll_locked = 1'b1;
      run_to(15); pll_locked = 1'b0;
      run_to(16); pll_locked = 1'b1;
      run_to(20); chk("gl_ch_20", ch_rst_n, 4'b0000);
      run_to(25); chk("gl_ch_25", ch_rst_n, 4'b0000);
      run_to(26); chk("gl_ch_26", ch_rst_n, 4'b0001);
                  chk("gl_loss", lock_loss_cnt, 0);
      run_to(38); chk("gl_ch_38", ch_rst_n, 4'b1111);
                  chk("gl_rdy_38", all_ready, 1);

      // Lock loss in RUN, then relock without a PLL reset pulse
      run_to(40); pll_locked = 1'b0;
      run_to(42); chk("ll_ch_42", ch_rst_n, 4'b1111);
      run_to(43); chk("ll_ch_43", ch_rst_n, 4'b0000);
                  chk("ll_rdy_43", all_ready, 0);
                  chk("ll_loss_43", lock_loss_cnt, 1);
                  chk("ll_pll_43", pll_rst, 0);
      run_to(45); pll_locked = 1'b1;
      run_to(50); chk("ll_pll_50", pll_rst, 0);
      run_to(54); chk("ll_ch_54", ch_rst_n, 4'b0000);
      run_to(55); chk("ll_ch_55", ch_rst_n, 4'b0001);
      run_to(67); chk("ll_ch_67", ch_rst_n, 4'b1111);
                  chk("ll_rdy_67", all_ready, 1);
                  chk("ll_loss_67", lock_loss_cnt, 1);

      // Lock timeout
      do_reset();
      run_to(34); chk("to_terr_34", timeout_err, 0);
                  chk("to_pll_34", pll_rst, 0);
      run_to(35); chk("to_terr_35", timeout_err, 1);
`ifdef NIOS2_C_PLL_RETRY_EN
                  chk("to_pll_35", pll_rst, 1);
      run_to(37); chk("to_pll_37", pll_rst, 1);
`else
                  chk("to_pll_35", pll_rst, 0);
      run_to(37); chk("to_pll_37", pll_rst, 0);
`endif
      run_to(38); chk("to_pll_38", pll_rst, 0);
      run_to(40); pll_locked = 1'b1;
      run_to(49); chk("to_ch_49", ch_rst_n, 4'b0000);
      run_to(50); chk("to_ch_50", ch_rst_n, 4'b0001);
                  chk("to_terr_50", timeout_err, 1);

      // Software reset coinciding with a lock loss in RUN
      run_to(62); chk("sw_rdy_62", all_ready, 1);
      run_to(65); pll_locked = 1'b0;
      run_to(67); sw_reset_req = 1'b1;
                  chk("sw_ch_67", ch_rst_n, 4'b1111);
                  chk("sw_pll_67", pll_rst, 0);
      run_to(68); sw_reset_req = 1'b0;
                  chk("sw_ch_68", ch_rst_n, 4'b0000);
                  chk("sw_rdy_68", all_ready, 0);
                  chk("sw_pll_68", pll_rst, 1);
                  chk("sw_loss_68", lock_loss_cnt, 1);
      run_to(70); chk("sw_pll_70", pll_rst, 1);
      run_to(71); chk("sw_pll_71", pll_rst, 0);
                  chk("sw_terr_71", timeout_err, 1);

      // Saturating loss counter: five losses during RELEASE
      do_reset();
      c = 5;
      for (int i = 0; i < 5; i++) begin
         run_to(c);      pll_locked = 1'b1;
         run_to(c + 10); chk("sat_ch_rel", ch_rst_n, 4'b0001);
                         pll_locked = 1'b0;
         run_to(c + 13); chk("sat_ch_lost", ch_rst_n, 4'b0000);
                         chk("sat_loss", lock_loss_cnt, (i < 3) ? (i + 1) : 3);
         c += 14;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nios2_c_pll_reset_seq.md
# nios2_c_pll_reset_seq

Parametrised clock-domain reset sequencer for the Nios II subsystem. It sits between the system PLL wrapper and the reset inputs of the PLL-clocked subsystems. It drives the PLL reset, synchronises and debounces the PLL `locked` flag, and releases up to `NUM_CH` domain resets in a fixed staggered order. It detects loss of lock and lock timeout and reports both.

## Interface
Parameters:
- `NUM_CH`, 4: number of sequenced reset outputs (≥1).
- `SYNC_STAGES`, 2: synchroniser depth for `pll_locked` (≥2).
- `PLL_RST_CYCLES`, 8: `pll_rst` pulse length (≥1).
- `LOCK_STABLE`, 1024: consecutive synced-lock cycles required before the first release (≥1).
- `STAGE_DLY`, 16: cycles between successive channel releases (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK.
- `CNT_W`, 8: width of the lock-loss counter.

Ports:
- `refclk` in 1: free-running reference clock; the whole block runs on it.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `sw_reset_req` in 1: synchronous, single-cycle request for a full resequence.
- `pll_rst` out 1: active-high reset to the PLL.
- `ch_rst_n` out NUM_CH: active-low domain resets; bit 0 releases first.
- `all_ready` out 1: high when every channel is released.
- `timeout_err` out 1: sticky; set by a lock timeout, cleared only by `rst_n`.
- `lock_loss_cnt` out CNT_W: saturating count of lock losses.

## Operation
- States:
  - PLL_RST: `pll_rst`=1 for `PLL_RST_CYCLES`, then → WAIT_LOCK.
  - WAIT_LOCK: waits for synced lock `lock_s`. `lock_s`=1 → STABLE. Timeout counter reaching `LOCK_TIMEOUT` → set `timeout_err`; next state per Configuration.
  - STABLE: counts consecutive `lock_s`=1. `lock_s`=0 → WAIT_LOCK with counters cleared; no loss count. Count reaches `LOCK_STABLE` → release `ch_rst_n[0]`, → RELEASE.
  - RELEASE: releases `ch_rst_n[k]` every `STAGE_DLY` cycles. After the last bit is released → RUN.
  - RUN: all released, `all_ready`=1.
- Loss of lock (`lock_s`=0 in RELEASE or RUN):
  - All `ch_rst_n` and `all_ready` go low on the next edge.
  - `lock_loss_cnt` increments, saturating at 2^CNT_W−1.
  - State → WAIT_LOCK. `pll_rst` is not pulsed.
- `sw_reset_req`=1 in any state:
  - All `ch_rst_n` go low on the next edge.
  - State → PLL_RST with all counters cleared.
  - Takes priority over every other transition.
- If `sw_reset_req` and a lock loss occur in the same cycle: `sw_reset_req` wins, and `lock_loss_cnt` still increments.
- Counter widths: `$clog2(param+1)`. Counters never wrap; they are cleared on every state entry.
- Released bits stay monotonic: once `ch_rst_n[k]`=1, bits below k stay 1 until a global reassertion.

## Timing
- Reset values while `rst_n`=0: state PLL_RST, `pll_rst`=1, `ch_rst_n`=0, `all_ready`=0, `timeout_err`=0, `lock_loss_cnt`=0.
- After `rst_n` deasserts: `pll_rst` stays high for exactly `PLL_RST_CYCLES` edges.
- `pll_locked` rise at edge E → `lock_s`=1 at E+`SYNC_STAGES` (call this T).
- `ch_rst_n[k]` rises at T+`LOCK_STABLE`+k·`STAGE_DLY`.
- `all_ready` rises on the same edge as `ch_rst_n[NUM_CH-1]`.
- `pll_locked` fall at edge F → `ch_rst_n` all low at F+`SYNC_STAGES`+1.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `NIOS2_C_PLL_RETRY_EN` defined: on lock timeout, set `timeout_err` and → PLL_RST. This re-pulses `pll_rst` and retries indefinitely.
- Undefined: on lock timeout, set `timeout_err` and stay in WAIT_LOCK with the timeout counter held. A later lock still proceeds normally; `timeout_err` stays set.

## Structure
- Package `nios2_c_clk_pkg` holds:
  - State enum typedef `pll_seq_state_t`.
  - Default parameter constants.
  - A `clog2`-based width helper.
- Sub-module `nios2_c_bit_sync`: a `SYNC_STAGES`-deep flop chain with async active-low reset to 0. It is instantiated once for `pll_locked`.
- The FSM and counters live in a single `always_ff` plus a next-state `always_comb`.

## Test plan
Bench parameters: `NUM_CH`=4, `SYNC_STAGES`=2, `PLL_RST_CYCLES`=3, `LOCK_STABLE`=8, `STAGE_DLY`=4, `LOCK_TIMEOUT`=32, `CNT_W`=2.
- Power-on: `rst_n` released at cycle 0, `pll_locked` rises at cycle 10 → `pll_rst` high through cycle 2; `ch_rst_n` bits rise at cycles 20/24/28/32; `all_ready` at 32.
- Lock glitch in STABLE: `pll_locked` low for 1 cycle at stable count 5 → release delayed by the full restart; `lock_loss_cnt` stays 0.
- Loss in RUN: `pll_locked` drops → `ch_rst_n`=0000 and `all_ready`=0 after 3 cycles; `lock_loss_cnt`=1; relock → full staggered release again, no `pll_rst` pulse.
- Timeout: `pll_locked` held low → `timeout_err`=1 at cycle 35.
  - With `NIOS2_C_PLL_RETRY_EN`: `pll_rst` re-pulses for 3 cycles.
  - Without it: `pll_rst` stays 0.
- `sw_reset_req` in RUN, in the same cycle as a lock drop → resets low next edge, `pll_rst` 3-cycle pulse, `lock_loss_cnt` +1.
- Saturation: 5 lock losses → `lock_loss_cnt`=3, no wrap.
